// File: rtl/dsp_pkg.sv
// Shared DSP-chain constants: ADC/FFT geometry and default band-window bins.
package dsp_pkg;
  localparam int ADC_DATLEN    = 12;
  localparam int FFT_VLEN      = 16;
  localparam int FFT_VLEN_LOG2 = 4;
  localparam int BAND_A_LO     = 3;   // 730 nm source
  localparam int BAND_A_HI     = 4;
  localparam int BAND_B_LO     = 6;   // 850 nm source
  localparam int BAND_B_HI     = 7;

  // An inverted window (lo > hi) never matches, so that band reports 0.
  function automatic logic in_window(input int bin, input int lo, input int hi);
    return (bin >= lo) && (bin <= hi);
  endfunction
endpackage

// File: rtl/chan_peak_acc.sv
// One channel's bin counter, band A/B peak accumulators and error flag.
// Results include the current sample and are valid while frame_done_o is high.
module chan_peak_acc
  import dsp_pkg::*;
#(
  parameter int DATA_W    = ADC_DATLEN,
  parameter int VLEN      = FFT_VLEN,
  parameter int VLEN_LOG2 = FFT_VLEN_LOG2,
  parameter int A_LO      = BAND_A_LO,
  parameter int A_HI      = BAND_A_HI,
  parameter int B_LO      = BAND_B_LO,
  parameter int B_HI      = BAND_B_HI
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              err_i,
  output logic              frame_done_o,
  output logic [DATA_W-1:0] max_a_o,
  output logic [DATA_W-1:0] max_b_o,
  output logic              err_o
);
  logic [VLEN_LOG2-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic                 err_q, err_d;
  logic                 hit_a, hit_b, last;

  always_comb begin
    hit_a        = in_window(int'(cnt_q), A_LO, A_HI);
    hit_b        = in_window(int'(cnt_q), B_LO, B_HI);
    last         = (cnt_q == VLEN_LOG2'(VLEN - 1));
    max_a_o      = (hit_a && (data_i > acc_a_q)) ? data_i : acc_a_q;
    max_b_o      = (hit_b && (data_i > acc_b_q)) ? data_i : acc_b_q;
    err_o        = err_q | err_i;
    frame_done_o = sample_i && last;

    cnt_d   = cnt_q;
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    err_d   = err_q;
    if (sample_i) begin
      if (last) begin
        cnt_d   = '0;
        acc_a_d = '0;
        acc_b_d = '0;
        err_d   = 1'b0;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        acc_a_d = max_a_o;
        acc_b_d = max_b_o;
        err_d   = err_o;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_a_q <= '0;
      acc_b_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: rtl/band_peak_tracker.sv
// Multi-channel band peak detector: demuxes interleaved FFT bins to per-channel
// accumulators and holds one frame result behind a valid/ready handshake.
module band_peak_tracker
  import dsp_pkg::*;
#(
  parameter int DATA_W    = ADC_DATLEN,
  parameter int VLEN      = FFT_VLEN,
  parameter int VLEN_LOG2 = FFT_VLEN_LOG2,
  parameter int CHANNELS  = 2,
  parameter int CH_W      = 1,
  parameter int A_LO      = BAND_A_LO,
  parameter int A_HI      = BAND_A_HI,
  parameter int B_LO      = BAND_B_LO,
  parameter int B_HI      = BAND_B_HI
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_chan,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_chan,
  output logic [DATA_W-1:0] out_max_a,
  output logic [DATA_W-1:0] out_max_b,
  output logic              out_err,
  output logic              overrun
);
  logic                             in_ok;
  logic [CHANNELS-1:0]              ch_done, ch_err;
  logic [CHANNELS-1:0][DATA_W-1:0]  ch_max_a, ch_max_b;

  logic                             any_done, sel_err;
  logic [CH_W-1:0]                  sel_chan;
  logic [DATA_W-1:0]                sel_a, sel_b;

  logic                             out_valid_q, out_valid_d, out_err_q, overrun_q, overrun_d;
  logic [CH_W-1:0]                  out_chan_q;
  logic [DATA_W-1:0]                out_max_a_q, out_max_b_q;

  // Out-of-range channel indices are dropped before reaching any accumulator.
  assign in_ok = in_valid && (int'(in_chan) < CHANNELS);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    chan_peak_acc #(
      .DATA_W(DATA_W), .VLEN(VLEN), .VLEN_LOG2(VLEN_LOG2),
      .A_LO(A_LO), .A_HI(A_HI), .B_LO(B_LO), .B_HI(B_HI)
    ) u_acc (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_i     (in_ok && (in_chan == CH_W'(g))),
      .data_i       (in_data),
      .err_i        (in_err),
      .frame_done_o (ch_done[g]),
      .max_a_o      (ch_max_a[g]),
      .max_b_o      (ch_max_b[g]),
      .err_o        (ch_err[g])
    );
  end

  // At most one channel can finish per cycle, so a plain select suffices.
  always_comb begin
    any_done = |ch_done;
    sel_chan = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_err  = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_done[c]) begin
        sel_chan = CH_W'(c);
        sel_a    = ch_max_a[c];
        sel_b    = ch_max_b[c];
        sel_err  = ch_err[c];
      end
    end

    out_valid_d = out_valid_q;
    if (any_done)                      out_valid_d = 1'b1;
    else if (out_valid_q && out_ready) out_valid_d = 1'b0;
    overrun_d = overrun_q | (any_done && out_valid_q && !out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_max_a_q <= '0;
      out_max_b_q <= '0;
      out_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      if (any_done) begin
        out_chan_q  <= sel_chan;
        out_max_a_q <= sel_a;
        out_max_b_q <= sel_b;
        out_err_q   <= sel_err;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_max_a = out_max_a_q;
  assign out_max_b = out_max_b_q;
  assign out_err   = out_err_q;
  assign overrun   = overrun_q;
endmodule
